jtag_hub_router: RTL and testbench
==================================

# jtag_hub_router

Parametrised JTAG hub that sits between the device scan-chain primitive and up to 255 user debug apps (debug cores, etc.). Each DR frame begins with an in-band header that selects a channel and a command. Data bits then route to that channel, to a 1-bit bypass, or out of a hub information register. All logic runs in the user-DR clock domain.

## Interface
- CTRL_PORT_NUM, 15: number of attached user apps; legal range 1..255.
- ID_W, 8: header ID field width; requires 2^ID_W > CTRL_PORT_NUM.
- HUB_VER, 8'h20: version byte reported by the query command.

Ports:
- drck_in  input  1  user-DR clock (TCK_USER); all flops on its rising edge.
- reset_dr  input  1  reset, asynchronous, active-high (TAP in TEST_LOGIC_RESET).
- tdi_in  input  1  scan data in.
- sel_in  input  1  user DR selected.
- capture_in  input  1  TAP in CAPTURE_DR.
- shift_in  input  1  TAP in SHIFT_DR.
- update_in  input  1  TAP in UPDATE_DR.
- tdo_out  output  1  scan data out (registered).
- drck_o  output  1  drck_in passthrough to apps.
- conf_tdi  output  1  registered tdi_in to apps.
- capt_o  output  1  capture_in & sel_in (combinational).
- shift_o  output  1  registered channel shift enable.
- conf_sel  output  CTRL_PORT_NUM  one-hot channel select.
- id_o  output  ID_W  latched channel ID.
- hub_tdo  input  CTRL_PORT_NUM  per-app read-back data.

## Operation
- Header: HDR_W = ID_W+2 bits, shifted LSB first. Bits [ID_W-1:0] = id; bits [ID_W+1:ID_W] = cmd.
- cmd encoding: 0 = route, 1 = query, 2/3 = bypass.
- State machine has three states: IDLE, HDR, DATA.
  - IDLE -> HDR on sel_in & capture_in. Header bit counter and header shift register are cleared.
  - HDR: on each shift_in cycle, shift tdi_in in and increment the counter.
  - HDR -> DATA on the cycle of the HDR_W-th header shift. id/cmd latch from {tdi_in, hdr_sr}. id_o is updated.
  - DATA: mode is fixed at header completion.
    - ROUTE if cmd==0 and id<CTRL_PORT_NUM.
    - QUERY if cmd==1.
    - Otherwise BYPASS. This includes id >= CTRL_PORT_NUM with cmd==0.
  - Any state -> IDLE on update_in or !sel_in. conf_sel clears to 0; id_o holds its value.
  - HDR/DATA -> HDR on sel_in & capture_in: new frame, counter cleared, conf_sel cleared.
  - If update_in and capture_in are both active, update_in wins.
- conf_sel[id] = 1 only in DATA/ROUTE; otherwise all zero.
- shift_o <= shift_in & (state==DATA) & ROUTE.
- conf_tdi <= tdi_in, every cycle.
- tdo_out is registered:
  - ROUTE: hub_tdo[id].
  - BYPASS: tdi_in, giving a standard 1-bit bypass register.
  - QUERY: info_sr[0].
  - IDLE/HDR: 0.
- info_sr (16 bit) is loaded with {HUB_VER, CTRL_PORT_NUM[7:0]} at header completion. It shifts right, zero-filled, on each DATA shift_in cycle. Bits beyond 16 read 0.
- Arithmetic: header counter width is clog2(HDR_W+1); it saturates at HDR_W. The id compare is unsigned at ID_W bits.

## Timing
- Reset values: tdo_out 0, conf_tdi 0, shift_o 0, conf_sel 0, id_o 0, state IDLE, info_sr 0, counter 0.
- Reset is asynchronous assert and clears the state mid-frame; the next frame needs a fresh capture.
- conf_sel asserts on the first cycle after the last header shift.
- shift_o and conf_tdi lag shift_in and tdi_in by 1 cycle, so they stay mutually aligned.
- hub_tdo -> tdo_out: 1 cycle. Host-seen round trip for ROUTE = 2 cycles plus app latency.
- BYPASS: a tdi bit entered at cycle n appears on tdo_out at cycle n+1.
- QUERY: the first info bit (bit 0) is on tdo_out one cycle after the first DATA shift.
- Header bits sampled while shift_in=0 are ignored (pause states).

## Configuration
- JTAG_HUB_QUERY_EN.
  - Defined: cmd 1 selects QUERY and info_sr is built.
  - Undefined: info_sr is not built and cmd 1 maps to BYPASS.

## Test plan
- Reset: assert reset_dr mid-DATA with channel 3 selected -> all outputs 0, state IDLE; with shifting and no capture, conf_sel stays 0.
- Route: CTRL_PORT_NUM=15, ID_W=8, header id=3/cmd=0 (10 bits) -> conf_sel=15'h0008 from the next cycle and id_o=3. Drive hub_tdo[3] with pattern 0xA5 -> 0xA5 on tdo_out delayed 1 cycle. Shift_o pulses match the number of data shifts.
- Bypass: header id=20, cmd=0 -> conf_sel=0. Shift tdi 1,0,1,1 -> tdo_out 0,1,0,1,1.
- Query: with JTAG_HUB_QUERY_EN, header cmd=1 -> first 16 data bits on tdo_out read 16'h200F LSB first, then zeros. Without the macro, the same header yields bypass behaviour.
- Frame control:
  - Capture in the middle of DATA restarts the header.
  - update_in ends the frame and clears conf_sel.
  - Dropping sel_in mid-header forces IDLE; id_o keeps its previous value.
- Pause: insert 5 cycles with shift_in=0 inside the header -> the header is still decoded correctly after HDR_W shifted bits.

Source files
------------

// File: rtl/jtag_hub_router.sv
// jtag_hub_router: in-band header JTAG hub that routes user-DR traffic to app channels.
// Define JTAG_HUB_QUERY_EN to build the hub information (query) register.
module jtag_hub_router #(
    parameter int         CTRL_PORT_NUM = 15,
    parameter int         ID_W          = 8,
    parameter logic [7:0] HUB_VER       = 8'h20
) (
    input  logic                     drck_in,
    input  logic                     reset_dr,
    input  logic                     tdi_in,
    input  logic                     sel_in,
    input  logic                     capture_in,
    input  logic                     shift_in,
    input  logic                     update_in,
    output logic                     tdo_out,
    output logic                     drck_o,
    output logic                     conf_tdi,
    output logic                     capt_o,
    output logic                     shift_o,
    output logic [CTRL_PORT_NUM-1:0] conf_sel,
    output logic [ID_W-1:0]          id_o,
    input  logic [CTRL_PORT_NUM-1:0] hub_tdo
);
    localparam int HDR_W = ID_W + 2;
    localparam int CNT_W = $clog2(HDR_W + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HDR_W - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(HDR_W);
    localparam logic [ID_W-1:0]  ID_LIM   = ID_W'(CTRL_PORT_NUM);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HDR  = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;

    localparam logic [1:0] MD_ROUTE  = 2'd0;
    localparam logic [1:0] MD_BYPASS = 2'd2;
`ifdef JTAG_HUB_QUERY_EN
    localparam logic [1:0] MD_QUERY  = 2'd1;
`endif

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [HDR_W-2:0] hdr_sr_q, hdr_sr_d;
    logic [ID_W-1:0]  id_q, id_d;
    logic [1:0]       mode_q, mode_d;
    logic             tdo_q, tdo_d;
    logic             conf_tdi_q, conf_tdi_d;
    logic             shift_q, shift_d;

    logic [HDR_W-1:0]         hdr_full;
    logic [ID_W-1:0]          hdr_id;
    logic [1:0]               hdr_cmd;
    logic [1:0]               hdr_mode;
    logic                     frame_ok;
    logic                     hdr_done;
    logic                     is_route;
    logic                     route_bit;
    logic [CTRL_PORT_NUM-1:0] sel_dec;

    // Full header as seen on the cycle of its last shift
    assign hdr_full = {tdi_in, hdr_sr_q};
    assign hdr_id   = hdr_full[ID_W-1:0];
    assign hdr_cmd  = hdr_full[HDR_W-1:ID_W];

    assign frame_ok = sel_in & ~update_in & ~capture_in;
    assign hdr_done = frame_ok & shift_in & (state_q == ST_HDR) &
                      (cnt_q == CNT_LAST);

    always_comb begin
        hdr_mode = MD_BYPASS;
        if (hdr_cmd == 2'd0 && hdr_id < ID_LIM) begin
            hdr_mode = MD_ROUTE;
        end
`ifdef JTAG_HUB_QUERY_EN
        else if (hdr_cmd == 2'd1) begin
            hdr_mode = MD_QUERY;
        end
`endif
    end

    // Update/deselect beat capture, capture beats shifting
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hdr_sr_d = hdr_sr_q;
        id_d     = id_q;
        mode_d   = mode_q;
        if (update_in || !sel_in) begin
            state_d = ST_IDLE;
        end else if (capture_in) begin
            state_d  = ST_HDR;
            cnt_d    = '0;
            hdr_sr_d = '0;
        end else if (state_q == ST_HDR && shift_in) begin
            hdr_sr_d = hdr_full[HDR_W-1:1];
            cnt_d    = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
            if (hdr_done) begin
                state_d = ST_DATA;
                id_d    = hdr_id;
                mode_d  = hdr_mode;
            end
        end
    end

    always_comb begin
        route_bit = 1'b0;
        sel_dec   = '0;
        for (int i = 0; i < CTRL_PORT_NUM; i++) begin
            if (id_q == ID_W'(i)) begin
                route_bit  = hub_tdo[i];
                sel_dec[i] = 1'b1;
            end
        end
    end

    assign is_route = (state_q == ST_DATA) & (mode_q == MD_ROUTE);

`ifdef JTAG_HUB_QUERY_EN
    logic [15:0] info_sr_q, info_sr_d;

    always_comb begin
        info_sr_d = info_sr_q;
        if (hdr_done) begin
            info_sr_d = {HUB_VER, 8'(CTRL_PORT_NUM)};
        end else if (frame_ok && shift_in && state_q == ST_DATA) begin
            info_sr_d = {1'b0, info_sr_q[15:1]};
        end
    end

    always_ff @(posedge drck_in or posedge reset_dr) begin
        if (reset_dr) begin
            info_sr_q <= '0;
        end else begin
            info_sr_q <= info_sr_d;
        end
    end
`else
    logic unused_ver;
    assign unused_ver = ^HUB_VER;
`endif

    always_comb begin
        tdo_d = 1'b0;
        if (state_q == ST_DATA) begin
            case (mode_q)
                MD_ROUTE: tdo_d = route_bit;
`ifdef JTAG_HUB_QUERY_EN
                MD_QUERY: tdo_d = info_sr_q[0];
`endif
                default:  tdo_d = tdi_in;
            endcase
        end
    end

    assign shift_d    = shift_in & is_route;
    assign conf_tdi_d = tdi_in;

    always_ff @(posedge drck_in or posedge reset_dr) begin
        if (reset_dr) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            hdr_sr_q   <= '0;
            id_q       <= '0;
            mode_q     <= MD_BYPASS;
            tdo_q      <= 1'b0;
            conf_tdi_q <= 1'b0;
            shift_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            hdr_sr_q   <= hdr_sr_d;
            id_q       <= id_d;
            mode_q     <= mode_d;
            tdo_q      <= tdo_d;
            conf_tdi_q <= conf_tdi_d;
            shift_q    <= shift_d;
        end
    end

    assign tdo_out  = tdo_q;
    assign conf_tdi = conf_tdi_q;
    assign shift_o  = shift_q;
    assign id_o     = id_q;
    assign conf_sel = is_route ? sel_dec : '0;
    assign drck_o   = drck_in;
    assign capt_o   = capture_in & sel_in;

endmodule

// File: tb/tb_jtag_hub_router.sv
// tb_jtag_hub_router: directed and randomized frame checks of jtag_hub_router
// against a queue-based header model.
module tb_jtag_hub_router;
    localparam int N     = 15;
    localparam int ID_W  = 8;
    localparam int HDR_W = ID_W + 2;
`ifdef JTAG_HUB_QUERY_EN
    localparam bit QRY = 1'b1;
`else
    localparam bit QRY = 1'b0;
`endif

    typedef struct packed {
        logic t;
        logic s;
        logic c;
        logic sh;
        logic u;
    } stim_t;

    logic            drck_in = 1'b0;
    logic            reset_dr, tdi_in, sel_in, capture_in, shift_in, update_in;
    logic [N-1:0]    hub_tdo;
    logic            tdo_out, drck_o, conf_tdi, capt_o, shift_o;
    logic [N-1:0]    conf_sel;
    logic [ID_W-1:0] id_o;

    jtag_hub_router #(
        .CTRL_PORT_NUM(N),
        .ID_W         (ID_W),
        .HUB_VER      (8'h20)
    ) dut (
        .drck_in   (drck_in),
        .reset_dr  (reset_dr),
        .tdi_in    (tdi_in),
        .sel_in    (sel_in),
        .capture_in(capture_in),
        .shift_in  (shift_in),
        .update_in (update_in),
        .tdo_out   (tdo_out),
        .drck_o    (drck_o),
        .conf_tdi  (conf_tdi),
        .capt_o    (capt_o),
        .shift_o   (shift_o),
        .conf_sel  (conf_sel),
        .id_o      (id_o),
        .hub_tdo   (hub_tdo)
    );

    always #5 drck_in = ~drck_in;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: frame phase 0=idle, 1=header, 2=data
    int              m_ph;
    bit              m_hdr[$];
    int              m_id;
    int              m_mode;
    int unsigned     m_info;
    logic            e_tdo, e_shift, e_ctdi;
    logic [N-1:0]    e_sel;
    logic [ID_W-1:0] e_id;

    task automatic model_reset();
        m_ph = 0;
        m_hdr.delete();
        m_id = 0;
        m_mode = 2;
        m_info = 0;
        e_tdo = 0;
        e_shift = 0;
        e_ctdi = 0;
        e_sel = '0;
        e_id = '0;
    endtask

    task automatic model_step();
        int id;
        int cmd;
        e_tdo = 1'b0;
        if (m_ph == 2) begin
            if (m_mode == 0) e_tdo = hub_tdo[m_id];
            else if (m_mode == 1) e_tdo = m_info[0];
            else e_tdo = tdi_in;
        end
        e_shift = shift_in && m_ph == 2 && m_mode == 0;
        e_ctdi = tdi_in;
        if (update_in || !sel_in) begin
            m_ph = 0;
        end else if (capture_in) begin
            m_ph = 1;
            m_hdr.delete();
        end else if (shift_in && m_ph == 1) begin
            m_hdr.push_back(tdi_in);
            if (m_hdr.size() == HDR_W) begin
                id = 0;
                for (int i = 0; i < ID_W; i++) id += int'(m_hdr[i]) << i;
                cmd = int'(m_hdr[ID_W]) + 2 * int'(m_hdr[ID_W+1]);
                m_id = id;
                e_id = ID_W'(id);
                if (cmd == 0 && id < N) m_mode = 0;
                else if (QRY && cmd == 1) m_mode = 1;
                else m_mode = 2;
                m_info = (32'h20 << 8) | 32'(N);
                m_ph = 2;
            end
        end else if (shift_in && m_ph == 2) begin
            m_info = m_info >> 1;
        end
        e_sel = '0;
        if (m_ph == 2 && m_mode == 0) e_sel[m_id] = 1'b1;
    endtask

    task automatic tick(input logic t, input logic s, input logic c,
                        input logic sh, input logic u);
        tdi_in = t;
        sel_in = s;
        capture_in = c;
        shift_in = sh;
        update_in = u;
        model_step();
        @(posedge drck_in);
        #1;
    endtask

    task automatic do_reset();
        reset_dr = 1'b1;
        tdi_in = 0;
        sel_in = 0;
        capture_in = 0;
        shift_in = 0;
        update_in = 0;
        hub_tdo = '0;
        @(posedge drck_in);
        @(posedge drck_in);
        #1;
        reset_dr = 1'b0;
        model_reset();
    endtask

    task automatic send_bits(input int id, input int cmd);
        logic [HDR_W-1:0] h;
        h = {2'(cmd), ID_W'(id)};
        for (int i = 0; i < HDR_W; i++) tick(h[i], 1, 0, 1, 0);
    endtask

    task automatic send_hdr(input int id, input int cmd);
        tick(0, 1, 1, 0, 0);
        send_bits(id, cmd);
    endtask

    task automatic test_reset();
        do_reset();
        n_chk++;
        if ({tdo_out, shift_o, conf_tdi, conf_sel, id_o} !== '0)
            $display("FAIL reset_vals got tdo=%b sh=%b ctdi=%b sel=%h id=%h exp all 0",
                     tdo_out, shift_o, conf_tdi, conf_sel, id_o);
        else n_pass++;
        send_hdr(3, 0);
        hub_tdo = N'(1) << 3;
        tick(1, 1, 0, 1, 0);
        n_chk++;
        if ({tdo_out, shift_o, conf_tdi, conf_sel} !== {3'b111, 15'h0008})
            $display("FAIL pre_reset got tdo=%b sh=%b ctdi=%b sel=%h exp 1 1 1 0008",
                     tdo_out, shift_o, conf_tdi, conf_sel);
        else n_pass++;
        #2 reset_dr = 1'b1;
        #1;
        n_chk++;
        if ({tdo_out, shift_o, conf_tdi, conf_sel, id_o} !== '0)
            $display("FAIL async_reset got tdo=%b sh=%b ctdi=%b sel=%h id=%h exp all 0",
                     tdo_out, shift_o, conf_tdi, conf_sel, id_o);
        else n_pass++;
        @(posedge drck_in);
        #1;
        reset_dr = 1'b0;
        model_reset();
        for (int i = 0; i < 12; i++) begin
            tick(1'($urandom), 1, 0, 1, 0);
            n_chk++;
            if (conf_sel !== '0 || tdo_out !== 1'b0)
                $display("FAIL post_reset_idle got sel=%h tdo=%b exp 0000 0",
                         conf_sel, tdo_out);
            else n_pass++;
        end
    endtask

    task automatic test_route();
        logic [7:0] pat;
        logic [7:0] got;
        logic       t;
        int         pulses;
        bit         tdi_ok;
        pat = 8'hA5;
        got = '0;
        pulses = 0;
        tdi_ok = 1;
        do_reset();
        tick(0, 1, 1, 0, 0);
        n_chk++;
        if (capt_o !== 1'b1 || drck_o !== drck_in)
            $display("FAIL capt_drck got capt=%b drck_o=%b exp 1 %b",
                     capt_o, drck_o, drck_in);
        else n_pass++;
        send_bits(3, 0);
        n_chk++;
        if (conf_sel !== 15'h0008 || id_o !== 8'd3)
            $display("FAIL route_sel got sel=%h id=%0d exp 0008 3", conf_sel, id_o);
        else n_pass++;
        for (int i = 0; i < 8; i++) begin
            hub_tdo = N'($urandom);
            hub_tdo[3] = pat[i];
            t = 1'($urandom);
            tick(t, 1, 0, 1, 0);
            got[i] = tdo_out;
            pulses += int'(shift_o);
            if (conf_tdi !== t) tdi_ok = 0;
        end
        n_chk++;
        if (got !== pat)
            $display("FAIL route_data got %h exp %h", got, pat);
        else n_pass++;
        n_chk++;
        if (pulses !== 8 || !tdi_ok)
            $display("FAIL route_shift got pulses=%0d tdi_ok=%0d exp 8 1", pulses, tdi_ok);
        else n_pass++;
        tick(0, 1, 0, 0, 0);
        n_chk++;
        if (shift_o !== 1'b0 || conf_sel !== 15'h0008)
            $display("FAIL route_idle_shift got sh=%b sel=%h exp 0 0008", shift_o, conf_sel);
        else n_pass++;
    endtask

    task automatic test_bypass();
        logic [3:0] bits;
        logic [4:0] obs;
        bits = 4'b1101;
        do_reset();
        send_hdr(20, 0);
        n_chk++;
        if (conf_sel !== '0 || id_o !== 8'd20)
            $display("FAIL bypass_sel got sel=%h id=%0d exp 0000 20", conf_sel, id_o);
        else n_pass++;
        obs[0] = tdo_out;
        for (int i = 0; i < 4; i++) begin
            tick(bits[i], 1, 0, 1, 0);
            obs[i+1] = tdo_out;
        end
        n_chk++;
        if (obs !== 5'b11010 || shift_o !== 1'b0)
            $display("FAIL bypass_data got obs=%b sh=%b exp 11010 0", obs, shift_o);
        else n_pass++;
    endtask

    task automatic test_query();
        logic [19:0] got;
        logic [19:0] tdis;
        logic [19:0] exp;
        do_reset();
        send_hdr(int'($urandom_range(0, 255)), 1);
        n_chk++;
        if (conf_sel !== '0)
            $display("FAIL query_sel got %h exp 0000", conf_sel);
        else n_pass++;
        for (int i = 0; i < 20; i++) begin
            tdis[i] = 1'($urandom);
            tick(tdis[i], 1, 0, 1, 0);
            got[i] = tdo_out;
        end
        exp = QRY ? 20'h0200F : tdis;
        n_chk++;
        if (got !== exp)
            $display("FAIL query_data got %h exp %h", got, exp);
        else n_pass++;
    endtask

    task automatic test_frame_control();
        logic [HDR_W-1:0] h;
        do_reset();
        send_hdr(5, 0);
        tick(1, 1, 0, 1, 0);
        tick(0, 1, 0, 1, 0);
        tick(0, 1, 1, 0, 0);
        n_chk++;
        if (conf_sel !== '0)
            $display("FAIL recapture_clear got %h exp 0000", conf_sel);
        else n_pass++;
        send_bits(7, 0);
        n_chk++;
        if (conf_sel !== 15'h0080 || id_o !== 8'd7)
            $display("FAIL recapture_route got sel=%h id=%0d exp 0080 7", conf_sel, id_o);
        else n_pass++;
        tick(0, 1, 0, 0, 1);
        n_chk++;
        if (conf_sel !== '0 || id_o !== 8'd7)
            $display("FAIL update_end got sel=%h id=%0d exp 0000 7", conf_sel, id_o);
        else n_pass++;
        h = {2'b00, 8'd9};
        tick(0, 1, 1, 0, 0);
        for (int i = 0; i < 4; i++) tick(h[i], 1, 0, 1, 0);
        tick(0, 0, 0, 1, 0);
        send_bits(9, 0);
        n_chk++;
        if (conf_sel !== '0 || id_o !== 8'd7)
            $display("FAIL sel_drop got sel=%h id=%0d exp 0000 7", conf_sel, id_o);
        else n_pass++;
        send_hdr(2, 0);
        tick(0, 1, 1, 0, 1);
        send_bits(4, 0);
        n_chk++;
        if (conf_sel !== '0 || id_o !== 8'd2)
            $display("FAIL update_over_capture got sel=%h id=%0d exp 0000 2",
                     conf_sel, id_o);
        else n_pass++;
    endtask

    task automatic test_pause();
        logic [HDR_W-1:0] h;
        h = {2'b00, 8'd9};
        do_reset();
        tick(0, 1, 1, 0, 0);
        for (int i = 0; i < 4; i++) tick(h[i], 1, 0, 1, 0);
        for (int i = 0; i < 5; i++) tick(1'($urandom), 1, 0, 0, 0);
        for (int i = 4; i < HDR_W; i++) tick(h[i], 1, 0, 1, 0);
        n_chk++;
        if (conf_sel !== 15'h0200 || id_o !== 8'd9)
            $display("FAIL pause_hdr got sel=%h id=%0d exp 0200 9", conf_sel, id_o);
        else n_pass++;
    endtask

    task automatic test_random();
        stim_t            q[$];
        stim_t            v;
        logic [HDR_W-1:0] h;
        int               len;
        do_reset();
        for (int f = 0; f < 80; f++) begin
            q.delete();
            h = {2'($urandom_range(0, 3)), ID_W'($urandom_range(0, 19))};
            v = '{t: 1'b0, s: 1'b1, c: 1'b1, sh: 1'b0, u: 1'b0};
            q.push_back(v);
            for (int i = 0; i < HDR_W; i++) begin
                while ($urandom_range(0, 4) == 0) begin
                    v = '{t: 1'($urandom), s: 1'b1, c: 1'b0, sh: 1'b0, u: 1'b0};
                    q.push_back(v);
                end
                v = '{t: h[i], s: 1'b1, c: 1'b0, sh: 1'b1, u: 1'b0};
                q.push_back(v);
            end
            len = int'($urandom_range(0, 24));
            for (int j = 0; j < len; j++) begin
                v.t  = 1'($urandom);
                v.s  = ($urandom_range(0, 39) != 0);
                v.c  = ($urandom_range(0, 49) == 0);
                v.sh = ($urandom_range(0, 3) != 0);
                v.u  = ($urandom_range(0, 49) == 0);
                q.push_back(v);
            end
            if ($urandom_range(0, 1) == 1) begin
                v = '{t: 1'b0, s: 1'b1, c: 1'b0, sh: 1'b0, u: 1'b1};
                q.push_back(v);
            end
            foreach (q[k]) begin
                hub_tdo = N'($urandom);
                tick(q[k].t, q[k].s, q[k].c, q[k].sh, q[k].u);
                n_chk++;
                if ({tdo_out, shift_o, conf_tdi, conf_sel, id_o} !==
                    {e_tdo, e_shift, e_ctdi, e_sel, e_id})
                    $display("FAIL rand f=%0d k=%0d got tdo=%b sh=%b ctdi=%b sel=%h id=%h exp %b %b %b %h %h",
                             f, k, tdo_out, shift_o, conf_tdi, conf_sel, id_o,
                             e_tdo, e_shift, e_ctdi, e_sel, e_id);
                else n_pass++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_route();
        test_bypass();
        test_query();
        test_frame_control();
        test_pause();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
